// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: FSM state encoding, command codes and baud-select encoding shared with rx_bps_ctrl
package uart_cmd_ctrl_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_S1 = 3'd1, ST_CMD = 3'd2, ST_ADDR = 3'd3;
  localparam logic [2:0] ST_DHI = 3'd4, ST_DLO = 3'd5, ST_CHK = 3'd6, ST_EXEC = 3'd7;
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE, S_S1 = ST_S1, S_CMD = ST_CMD, S_ADDR = ST_ADDR,
    S_DHI = ST_DHI, S_DLO = ST_DLO, S_CHK = ST_CHK, S_EXEC = ST_EXEC
  } state_t;
  localparam logic [7:0] CMD_REG_WR = 8'h01, CMD_SET_BAUD = 8'h02;
  localparam logic [2:0] BAUD_9600 = 3'd0, BAUD_19200 = 3'd1, BAUD_38400 = 3'd2, BAUD_57600 = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4, BAUD_230400 = 3'd5, BAUD_460800 = 3'd6, BAUD_921600 = 3'd7;
endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte timeout counter; expire pulses when CYCLES-1 is reached without a clear
module uart_cmd_timeout #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  assign expire = en && !clr && cnt == W'(CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !en || expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses A5 5A CMD ADDR DHI DLO CHK frames into register writes or baud changes.
// Define UART_CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_MS of line silence.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int UART_CLK_MHZ = 50,
  parameter int TIMEOUT_MS = 10,
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        reg_wr_en_o,
  input  logic        reg_wr_ack_i,
  output logic [7:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o,
  output logic [2:0]  baud_sel_o,
  output logic        frame_err_o,
  output logic        rx_drop_o,
  output logic        busy_o
);
  state_t state;
  logic [7:0] cmd_q, dhi_q, dlo_q, chk_acc;
  logic to_expire;
  assign busy_o = state != S_IDLE;
  assign reg_wdata_o = {dhi_q, dlo_q};
`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timeout #(.CYCLES(UART_CLK_MHZ * 1000 * TIMEOUT_MS)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rx_valid_i),
    .en    (state != S_IDLE && state != S_EXEC),
    .expire(to_expire)
  );
`else
  assign to_expire = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      reg_addr_o  <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      chk_acc     <= '0;
      reg_wr_en_o <= 1'b0;
      baud_sel_o  <= BAUD_9600;
      frame_err_o <= 1'b0;
      rx_drop_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      rx_drop_o   <= 1'b0;
      if (to_expire) begin
        frame_err_o <= 1'b1;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (rx_valid_i && rx_data_i == SYNC0) state <= S_S1;
          S_S1: if (rx_valid_i)
            state <= rx_data_i == SYNC1 ? S_CMD : rx_data_i == SYNC0 ? S_S1 : S_IDLE;
          S_CMD: if (rx_valid_i) begin
            cmd_q   <= rx_data_i;
            chk_acc <= rx_data_i;
            state   <= S_ADDR;
          end
          S_ADDR: if (rx_valid_i) begin
            reg_addr_o <= rx_data_i;
            chk_acc    <= chk_acc ^ rx_data_i;
            state      <= S_DHI;
          end
          S_DHI: if (rx_valid_i) begin
            dhi_q   <= rx_data_i;
            chk_acc <= chk_acc ^ rx_data_i;
            state   <= S_DLO;
          end
          S_DLO: if (rx_valid_i) begin
            dlo_q   <= rx_data_i;
            chk_acc <= chk_acc ^ rx_data_i;
            state   <= S_CHK;
          end
          S_CHK: if (rx_valid_i) begin
            if (rx_data_i == chk_acc && cmd_q == CMD_REG_WR) begin
              reg_wr_en_o <= 1'b1;
              state       <= S_EXEC;
            end else begin
              state <= S_IDLE;
              if (rx_data_i == chk_acc && cmd_q == CMD_SET_BAUD) baud_sel_o <= dlo_q[2:0];
              else frame_err_o <= 1'b1;
            end
          end
          S_EXEC: begin
            rx_drop_o <= rx_valid_i;
            if (reg_wr_en_o && reg_wr_ack_i) begin
              reg_wr_en_o <= 1'b0;
              state       <= S_IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule
